// File: rtl/vga_pkg.sv
// vga_pkg: shared scheduler state encoding and display geometry for the VGA/SRAM path
package vga_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR} sched_state_t;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
endpackage

// File: rtl/vga_sram_scheduler_if.sv
// vga_sram_scheduler_if: line-buffer, renderer-write and SRAM pin bundle around the scheduler
interface vga_sram_scheduler_if import vga_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              line_start;
    logic [ADDR_W-1:0] line_base;
    logic              buf_we;
    logic [6:0]        buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              fetch_done;
    logic              overrun;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    modport master (
        input  line_start, line_base, wr_valid, wr_addr, wr_data, sram_dq_i,
        output buf_we, buf_addr, buf_data, fetch_done, overrun, wr_ready,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
    modport slave (
        output line_start, line_base, wr_valid, wr_addr, wr_data, sram_dq_i,
        input  buf_we, buf_addr, buf_data, fetch_done, overrun, wr_ready,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_access_timer.sv
// sram_access_timer: counts cycles of the current SRAM access and flags its last cycle and write-enable window
module sram_access_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic busy,
    output logic last,
    output logic we_win
);
    localparam int CW = $clog2(ACCESS_CYCLES);
    logic [CW-1:0] cnt;
    // advance through the access and wrap to zero on its last cycle so chained accesses start fresh
    always_ff @(posedge CLK or posedge RST)
        if (RST) cnt <= '0;
        else cnt <= (busy && !last) ? cnt + 1'b1 : '0;
    assign last = busy && cnt == CW'(ACCESS_CYCLES - 1);
    assign we_win = busy && !last;
endmodule

// File: rtl/vga_sram_scheduler.sv
// vga_sram_scheduler: shares the frame-buffer SRAM between display line prefetch (priority) and renderer writes
module vga_sram_scheduler import vga_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS_PER_LINE = TEXT_COLS,
    parameter int ACCESS_CYCLES = 2
) (
    input logic CLK,
    input logic RST,
    vga_sram_scheduler_if.master bus
);
    sched_state_t state, state_nxt;
    logic last, we_win, pend, pend_nxt, abrt, rd_ok, decide, wr_fire, last_word;
    logic [6:0] idx, idx_nxt;
    logic [ADDR_W-1:0] base, base_nxt, acc_addr;
    logic [DATA_W-1:0] wd;

    sram_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .CLK, .RST, .busy(state != IDLE), .last, .we_win
    );

    assign bus.wr_ready = state == IDLE && !pend && !bus.line_start;
    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign last_word = idx == 7'(WORDS_PER_LINE - 1);
    assign rd_ok = state == RD && last && !abrt && !bus.line_start;
    assign decide = state == IDLE || last;
    assign bus.sram_addr = acc_addr;
    assign bus.sram_dq_o = wd;
    assign bus.sram_dq_oe = state == WR;
    assign bus.sram_ce_n = state == IDLE;
    assign bus.sram_oe_n = state != RD;
    assign bus.sram_we_n = !(state == WR && we_win);

    // fetch bookkeeping and the arbitration decision, taken in IDLE or on the last cycle of an access
    always_comb begin
        base_nxt = bus.line_start ? bus.line_base : base;
        idx_nxt = bus.line_start ? 7'd0 : idx + 7'(rd_ok);
        pend_nxt = bus.line_start || (pend && !(rd_ok && last_word));
        state_nxt = !decide ? state : pend_nxt ? RD : wr_fire ? WR : IDLE;
    end

    // state register
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else state <= state_nxt;

    // line fetch progress, latched access address/data, and line-buffer write-back of completed reads
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            base <= '0;
            idx <= '0;
            pend <= 1'b0;
            abrt <= 1'b0;
            acc_addr <= '0;
            wd <= '0;
            bus.overrun <= 1'b0;
            bus.buf_we <= 1'b0;
            bus.fetch_done <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_data <= '0;
        end else begin
            base <= base_nxt;
            idx <= idx_nxt;
            pend <= pend_nxt;
            abrt <= state == RD && !last && (abrt || bus.line_start);
            bus.overrun <= bus.overrun || (bus.line_start && (pend || state == RD));
            if (decide && state_nxt == RD) acc_addr <= base_nxt + ADDR_W'(idx_nxt);
            else if (wr_fire) begin
                acc_addr <= bus.wr_addr;
                wd <= bus.wr_data;
            end
            bus.buf_we <= rd_ok;
            bus.fetch_done <= rd_ok && last_word;
            if (rd_ok) begin
                bus.buf_addr <= idx;
                bus.buf_data <= bus.sram_dq_i;
            end
        end
    end
endmodule

// File: tb/tb_vga_sram_scheduler.sv
// tb_vga_sram_scheduler: randomized scenarios checked against a behavioural SRAM and fetch-timing model
module tb_vga_sram_scheduler;
    import vga_pkg::*;
    localparam int AW = 20, DW = 16, WPL = 80, AC = 2;
    typedef struct { int c; logic [6:0] a; logic [DW-1:0] d; } bw_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int cyc = 0, n_chk = 0, n_fail = 0;
    bw_t bw_q[$];
    int fd_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    vga_sram_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    vga_sram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .ACCESS_CYCLES(AC)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // cycle number, advanced on every rising edge
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : a[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // SRAM model plus line-buffer monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (!bus.sram_ce_n && !bus.sram_we_n) begin
            check("wr strobes", {bus.sram_oe_n, bus.sram_dq_oe}, 2'b11);
            mem[bus.sram_addr] = bus.sram_dq_o;
        end
        bus.sram_dq_i = mem_rd(bus.sram_addr);
        if (bus.buf_we) bw_q.push_back('{cyc, bus.buf_addr, bus.buf_data});
        if (bus.fetch_done) fd_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic start_line(input logic [AW-1:0] base, output int t);
        bus.line_start = 1'b1;
        bus.line_base = base;
        t = cyc;
        tick();
        bus.line_start = 1'b0;
    endtask

    task automatic check_words(input string tag, input int t0, input logic [AW-1:0] base, input int n);
        bw_t e;
        for (int k = 0; k < n && bw_q.size() > 0; k++) begin
            e = bw_q.pop_front();
            check({tag, " cyc"}, e.c, t0 + k * AC);
            check({tag, " idx"}, e.a, k);
            check({tag, " data"}, e.d, mem_rd(base + AW'(k)));
        end
    endtask

    task automatic check_line(input string tag, input int t0, input logic [AW-1:0] base);
        check({tag, " words"}, bw_q.size(), WPL);
        check({tag, " done n"}, fd_q.size(), 1);
        if (fd_q.size() > 0) check({tag, " done cyc"}, fd_q[0], t0 + (WPL - 1) * AC);
        check_words(tag, t0, base, WPL);
        bw_q.delete();
        fd_q.delete();
    endtask

    initial begin
        logic [AW-1:0] b, b2, wa, wa2;
        logic [DW-1:0] wdat, wdat2;
        int t, t_rdy;
        bus.line_start = 1'b0;
        bus.line_base = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe,
                              bus.buf_we, bus.fetch_done, bus.overrun}, 7'b1110000);
        check("rst addr", bus.sram_addr, 0);
        check("rst dq_o", bus.sram_dq_o, 0);
        check("rst buf", {bus.buf_addr, bus.buf_data}, 0);
        tick();
        RST = 1'b0;

        // overrun, then reset in the second cycle of a read
        b = AW'($urandom_range(0, 'h7FFFF));
        b2 = AW'($urandom_range(0, 'h7FFFF));
        tick();
        start_line(b, t);
        wait_cycles(2);
        bus.line_start = 1'b1;
        bus.line_base = b2;
        tick();
        bus.line_start = 1'b0;
        @(negedge CLK);
        check("ovr set", bus.overrun, 1);
        tick();
        tick();
        #2 RST = 1'b1;
        #1;
        check("rst async strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe,
                                    bus.buf_we, bus.fetch_done, bus.overrun}, 7'b1110000);
        check("rst async addr", bus.sram_addr, 0);
        tick();
        RST = 1'b0;
        wait_cycles(6);
        check("rst ovr clr", bus.overrun, 0);
        check("rst idle ce_n", bus.sram_ce_n, 1);
        check("rst words", bw_q.size(), 1);
        check("rst done", fd_q.size(), 0);
        check_words("rst pre", t + AC + 1, b, 1);
        bw_q.delete();
        fd_q.delete();

        // plain line fetches from idle
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? AW'('h100) : AW'($urandom_range(0, 'h7FFFF));
            tick();
            start_line(b, t);
            wait_cycles(WPL * AC + 6);
            check_line("line", t + AC + 1, b);
            check("line no ovr", bus.overrun, 0);
        end

        // single writes from idle
        for (int i = 0; i < 3; i++) begin
            wa = (i == 0) ? AW'('h12345) : AW'($urandom);
            wdat = (i == 0) ? 16'hBEEF : DW'($urandom);
            tick();
            bus.wr_valid = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wdat;
            @(negedge CLK);
            check("wr ready", bus.wr_ready, 1);
            tick();
            bus.wr_valid = 1'b0;
            bus.wr_addr = '0;
            bus.wr_data = '0;
            @(negedge CLK);
            check("wr ph1 strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}, 4'b0011);
            check("wr ph1 addr", bus.sram_addr, wa);
            check("wr ph1 data", bus.sram_dq_o, wdat);
            tick();
            @(negedge CLK);
            check("wr ph2 strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}, 4'b0111);
            check("wr ph2 addr/data", {bus.sram_addr, bus.sram_dq_o}, {wa, wdat});
            tick();
            @(negedge CLK);
            check("wr rest ce_n", bus.sram_ce_n, 1);
            check("wr mem", mem_rd(wa), wdat);
        end

        // writer streaming, line_start lands during a write
        wa = AW'($urandom);
        wdat = DW'($urandom);
        wa2 = AW'($urandom);
        wdat2 = DW'($urandom);
        b = AW'($urandom_range(0, 'h7FFFF));
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wdat;
        @(negedge CLK);
        check("ws ready0", bus.wr_ready, 1);
        tick();
        bus.line_start = 1'b1;
        bus.line_base = b;
        t = cyc;
        bus.wr_addr = wa2;
        bus.wr_data = wdat2;
        @(negedge CLK);
        check("ws busy ready", bus.wr_ready, 0);
        tick();
        bus.line_start = 1'b0;
        t_rdy = -1;
        for (int i = 0; i < WPL * AC + 40 && t_rdy < 0; i++) begin
            @(negedge CLK);
            if (bus.wr_ready) t_rdy = cyc;
        end
        check("ws ready rise", t_rdy, t + AC + WPL * AC);
        tick();
        bus.wr_valid = 1'b0;
        @(negedge CLK);
        check("ws next wr we_n", bus.sram_we_n, 0);
        check("ws next wr addr", bus.sram_addr, wa2);
        check_line("ws line", t + 2 * AC, b);
        check("ws mem0", mem_rd(wa), wdat);
        wait_cycles(3);
        check("ws mem1", mem_rd(wa2), wdat2);

        // line_start and wr_valid together in idle: the read wins
        wa = AW'($urandom);
        wdat = DW'($urandom);
        b = AW'($urandom_range(0, 'h7FFFF));
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wdat;
        bus.line_start = 1'b1;
        bus.line_base = b;
        t = cyc;
        @(negedge CLK);
        check("tie ready", bus.wr_ready, 0);
        tick();
        bus.line_start = 1'b0;
        @(negedge CLK);
        check("tie rd strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}, 4'b0010);
        check("tie rd addr", bus.sram_addr, b);
        t_rdy = -1;
        for (int i = 0; i < WPL * AC + 40 && t_rdy < 0; i++) begin
            @(negedge CLK);
            if (bus.wr_ready) t_rdy = cyc;
        end
        check("tie ready rise", t_rdy, t + WPL * AC + 1);
        tick();
        bus.wr_valid = 1'b0;
        @(negedge CLK);
        check("tie wr addr", {bus.sram_we_n, bus.sram_addr}, {1'b0, wa});
        check_line("tie line", t + AC + 1, b);
        wait_cycles(3);
        check("tie mem", mem_rd(wa), wdat);

        // second line_start while read idx 10 is in flight
        b = AW'($urandom_range(0, 'h7FFFF));
        b2 = AW'('h200);
        tick();
        start_line(b, t);
        wait_cycles(10 * AC);
        bus.line_start = 1'b1;
        bus.line_base = b2;
        tick();
        bus.line_start = 1'b0;
        @(negedge CLK);
        check("ovr2 set", bus.overrun, 1);
        wait_cycles(WPL * AC + 10);
        check("ovr2 sticky", bus.overrun, 1);
        check("ovr2 words", bw_q.size(), 10 + WPL);
        check("ovr2 done n", fd_q.size(), 1);
        if (fd_q.size() > 0) check("ovr2 done cyc", fd_q[0], t + 1 + 10 * AC + WPL * AC + AC);
        check_words("ovr2 old", t + AC + 1, b, 10);
        check_words("ovr2 new", t + 1 + 10 * AC + 2 * AC, b2, WPL);
        bw_q.delete();
        fd_q.delete();

        // base near the top of the address space wraps to zero
        b = AW'('hFFFF0);
        tick();
        start_line(b, t);
        wait_cycles(16 * AC);
        @(negedge CLK);
        check("wrap addr", bus.sram_addr, 0);
        wait_cycles(WPL * AC);
        check_line("wrap", t + AC + 1, b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
